// File: rtl/pmod_jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI responder.
// Frame byte layout and command decode live here so the initiator side can share them.
package pmod_jstk_pkg;

  localparam int unsigned JSTK_NBYTES     = 5;
  localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;

  localparam int unsigned BYTE_X_LO = 0;
  localparam int unsigned BYTE_X_HI = 1;
  localparam int unsigned BYTE_Y_LO = 2;
  localparam int unsigned BYTE_Y_HI = 3;
  localparam int unsigned BYTE_BTN  = 4;

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    ACTIVE
  } jstk_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] buttons;
  } jstk_sample_t;

  // Byte idx of the outgoing frame; anything past the defined layout reads as zero.
  function automatic logic [7:0] jstk_tx_byte(input int unsigned idx, input jstk_sample_t s);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      BYTE_X_LO: b = s.x[7:0];
      BYTE_X_HI: b = {6'b0, s.x[9:8]};
      BYTE_Y_LO: b = s.y[7:0];
      BYTE_Y_HI: b = {6'b0, s.y[9:8]};
      BYTE_BTN:  b = {5'b0, s.buttons};
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic jstk_cmd_valid(input logic [7:0] cmd);
    return cmd[7:2] == JSTK_CMD_PREFIX;
  endfunction

endpackage

// File: rtl/spi_mode0_slave_shifter.sv
// SPI mode-0 device-side shifter: input synchronizers, registered edge strobes,
// bit counter and TX/RX shift registers. Framing decisions are left to the parent.
module spi_mode0_slave_shifter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic       clear_i,
  input  logic [7:0] tx_byte_i,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       cs_high_o,
  output logic       miso_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic [2:0] bit_cnt_o,
  output logic       tx_load_req_c
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q, mosi_q;
  logic       sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  logic       byte_done_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] tx_q, rx_q;
  logic       sclk_s, cs_s, mosi_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // CS resets to "low" so a select held across reset is never mistaken for a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      mosi_q      <= mosi_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
    end
  end

  assign tx_load_req_c = en_i & ~clear_i & ~load_i & sclk_fall_q & (bit_cnt_q == 3'd0);

  // Sample MOSI on SCLK rise, advance MISO on SCLK fall; clear beats load beats shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      if (clear_i) begin
        tx_q      <= '0;
        rx_q      <= '0;
        bit_cnt_q <= '0;
      end else if (load_i) begin
        tx_q      <= tx_byte_i;
        rx_q      <= '0;
        bit_cnt_q <= '0;
      end else if (en_i) begin
        if (sclk_rise_q) begin
          rx_q        <= {rx_q[6:0], mosi_q};
          bit_cnt_q   <= 3'(bit_cnt_q + 3'd1);
          byte_done_q <= (bit_cnt_q == 3'd7);
        end
        if (sclk_fall_q) begin
          tx_q <= (bit_cnt_q == 3'd0) ? tx_byte_i : {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  assign cs_fall_o   = cs_fall_q;
  assign cs_rise_o   = cs_rise_q;
  assign cs_high_o   = cs_s;
  assign miso_o      = tx_q[7];
  assign byte_done_o = byte_done_q;
  assign rx_byte_o   = rx_q;
  assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: rtl/pmod_jstk_responder.sv
// PmodJSTK emulator: returns a position/button frame over SPI mode 0 and
// decodes the initiator's command byte into the LED outputs.
module pmod_jstk_responder
  import pmod_jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NBYTES      = JSTK_NBYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic       MISO,
  output logic [1:0] led,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int unsigned BCW = $clog2(NBYTES + 1);

  jstk_state_e  state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic         ovf_q, ovf_d;
  jstk_sample_t snap_q, snap_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [1:0]   led_q, led_d;
  logic         done_q, done_d, err_q, err_d;

  logic         cs_fall, cs_rise, cs_high, byte_done, tx_load_req;
  logic [7:0]   rx_byte, tx_byte_c;
  logic [2:0]   bit_cnt;
  logic         load_c, en_c, clear_c;
  jstk_sample_t live_c;
  int unsigned  next_idx_c;

  assign live_c     = jstk_sample_t'({x_pos, y_pos, buttons});
  assign next_idx_c = 32'(byte_cnt_q) + 32'd1;

  // CS rise outranks any SCLK strobe in the same cycle by dropping the shifter enable.
  assign load_c  = (state_q == IDLE) && cs_fall;
  assign en_c    = (state_q == ACTIVE) && !cs_rise;
  assign clear_c = !load_c && !en_c;

  assign tx_byte_c = load_c ? jstk_tx_byte(BYTE_X_LO, live_c)
                   : ((next_idx_c < NBYTES) ? jstk_tx_byte(next_idx_c, snap_q) : 8'h00);

  spi_mode0_slave_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .sclk_i       (SCLK),
    .cs_i         (CS),
    .mosi_i       (MOSI),
    .en_i         (en_c),
    .load_i       (load_c),
    .clear_i      (clear_c),
    .tx_byte_i    (tx_byte_c),
    .cs_fall_o    (cs_fall),
    .cs_rise_o    (cs_rise),
    .cs_high_o    (cs_high),
    .miso_o       (MISO),
    .byte_done_o  (byte_done),
    .rx_byte_o    (rx_byte),
    .bit_cnt_o    (bit_cnt),
    .tx_load_req_c(tx_load_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_RELEASE;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
      snap_q     <= '0;
      cmd_q      <= '0;
      led_q      <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
      snap_q     <= snap_d;
      cmd_q      <= cmd_d;
      led_q      <= led_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Framing FSM; ovf_q marks a frame that ran past NBYTES while the counter saturated.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    snap_d     = snap_q;
    cmd_d      = cmd_q;
    led_d      = led_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      WAIT_RELEASE: begin
        if (cs_high) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          snap_d     = live_c;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
          cmd_d      = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt == 3'd0 && byte_cnt_q == BCW'(NBYTES) && !ovf_q) begin
            done_d = 1'b1;
            if (jstk_cmd_valid(cmd_q)) led_d = cmd_q[1:0];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (tx_load_req) begin
            if (byte_cnt_q == BCW'(NBYTES)) ovf_d = 1'b1;
            else byte_cnt_d = BCW'(byte_cnt_q + BCW'(1));
          end
          if (byte_done && byte_cnt_q == '0) cmd_d = rx_byte;
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  assign led         = led_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Directed bench for pmod_jstk_responder: drives SPI frames as a mode-0 initiator
// and checks returned bytes, pulses and LED decode against hand-computed values.
module tb_pmod_jstk_responder;

  logic       clk = 1'b0;
  logic       rst, SCLK, CS, MOSI;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       MISO;
  logic [1:0] led;
  logic       frame_done, frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_buf [0:7];
  logic [7:0] rx_buf [0:7];
  int         done_n, err_n, done_at, err_at;
  int         chg_bit = -1;
  logic [9:0] chg_val = 10'h000;

  pmod_jstk_responder #(.SYNC_STAGES(2), .NBYTES(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .SCLK       (SCLK),
    .CS         (CS),
    .MOSI       (MOSI),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .MISO       (MISO),
    .led        (led),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic clear_bufs();
    for (int i = 0; i < 8; i++) begin
      tx_buf[i] = 8'h00;
      rx_buf[i] = 8'h00;
    end
  endtask

  task automatic watch_pulses();
    done_n = 0; err_n = 0; done_at = 0; err_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin done_n++; if (done_at == 0) done_at = k; end
      if (frame_error === 1'b1) begin err_n++; if (err_at == 0) err_at = k; end
    end
  endtask

  task automatic xfer(input int nbits);
    CS = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_val;
      MOSI = tx_buf[3'(i / 8)][3'(7 - (i % 8))];
      repeat (10) @(negedge clk);
      rx_buf[3'(i / 8)][3'(7 - (i % 8))] = MISO;
      SCLK = 1'b1;
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (10) @(negedge clk);
    CS = 1'b1;
    watch_pulses();
    repeat (10) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
    repeat (4) @(negedge clk);
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led: got %b expected 00", led); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", frame_error); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_b [0:4];
    exp_b[0] = 8'hA5; exp_b[1] = 8'h02; exp_b[2] = 8'h3C; exp_b[3] = 8'h01; exp_b[4] = 8'h05;
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    clear_bufs(); tx_buf[0] = 8'h81;
    xfer(40);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx_buf[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_buf[i], exp_b[i]);
      end
    end
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_n); end
    n_checks++; if (done_at !== 4) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected 4", done_at); end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL basic_error_count: got %0d expected 0", err_n); end
    n_checks++; if (led !== 2'b01) begin n_fail++; $display("FAIL basic_led: got %b expected 01", led); end
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL basic_miso_idle: got %b expected 0", MISO); end
  endtask

  task automatic test_snapshot();
    clear_bufs(); tx_buf[0] = 8'h81;
    chg_bit = 4; chg_val = 10'h3FF;
    xfer(40);
    chg_bit = -1;
    n_checks++; if (rx_buf[0] !== 8'hA5) begin n_fail++; $display("FAIL snap_byte0: got %h expected a5", rx_buf[0]); end
    n_checks++; if (rx_buf[1] !== 8'h02) begin n_fail++; $display("FAIL snap_byte1: got %h expected 02", rx_buf[1]); end
    clear_bufs(); tx_buf[0] = 8'h81;
    xfer(40);
    n_checks++; if (rx_buf[0] !== 8'hFF) begin n_fail++; $display("FAIL snap_next_byte0: got %h expected ff", rx_buf[0]); end
    n_checks++; if (rx_buf[1] !== 8'h03) begin n_fail++; $display("FAIL snap_next_byte1: got %h expected 03", rx_buf[1]); end
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL snap_done_count: got %0d expected 1", done_n); end
  endtask

  task automatic test_invalid_cmd();
    clear_bufs(); tx_buf[0] = 8'h43;
    xfer(40);
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL badcmd_done_count: got %0d expected 1", done_n); end
    n_checks++; if (led !== 2'b01) begin n_fail++; $display("FAIL badcmd_led: got %b expected 01", led); end
  endtask

  task automatic test_short_frame();
    clear_bufs(); tx_buf[0] = 8'h82;
    xfer(12);
    n_checks++; if (err_n !== 1) begin n_fail++; $display("FAIL short_error_count: got %0d expected 1", err_n); end
    n_checks++; if (err_at !== 4) begin n_fail++; $display("FAIL short_error_latency: got %0d expected 4", err_at); end
    n_checks++; if (done_n !== 0) begin n_fail++; $display("FAIL short_done_count: got %0d expected 0", done_n); end
    n_checks++; if (led !== 2'b01) begin n_fail++; $display("FAIL short_led: got %b expected 01", led); end
    clear_bufs(); tx_buf[0] = 8'h82;
    xfer(40);
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL after_short_done: got %0d expected 1", done_n); end
    n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL after_short_led: got %b expected 10", led); end
  endtask

  task automatic test_long_frame();
    clear_bufs(); tx_buf[0] = 8'h81;
    rx_buf[5] = 8'hAA;
    xfer(48);
    n_checks++; if (rx_buf[4] !== 8'h05) begin n_fail++; $display("FAIL long_byte4: got %h expected 05", rx_buf[4]); end
    n_checks++; if (rx_buf[5] !== 8'h00) begin n_fail++; $display("FAIL long_byte5: got %h expected 00", rx_buf[5]); end
    n_checks++; if (err_n !== 1) begin n_fail++; $display("FAIL long_error_count: got %0d expected 1", err_n); end
    n_checks++; if (done_n !== 0) begin n_fail++; $display("FAIL long_done_count: got %0d expected 0", done_n); end
    n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL long_led: got %b expected 10", led); end
  endtask

  task automatic test_reset_midframe();
    logic activity;
    clear_bufs(); tx_buf[0] = 8'h81; tx_buf[1] = 8'h81;
    CS = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      MOSI = tx_buf[3'(i / 8)][3'(7 - (i % 8))];
      repeat (10) @(negedge clk);
      SCLK = 1'b1;
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b expected 0", MISO); end
    n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL rstmid_led: got %b expected 00", led); end
    activity = 1'b0;
    for (int i = 0; i < 16; i++) begin
      MOSI = tx_buf[3'(i / 8)][3'(7 - (i % 8))];
      repeat (10) begin
        @(negedge clk);
        if (MISO !== 1'b0 || frame_done !== 1'b0 || frame_error !== 1'b0) activity = 1'b1;
      end
      SCLK = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (MISO !== 1'b0 || frame_done !== 1'b0 || frame_error !== 1'b0) activity = 1'b1;
      end
      SCLK = 1'b0;
    end
    n_checks++; if (activity !== 1'b0) begin n_fail++; $display("FAIL rstmid_ignored_sclk: got %b expected 0", activity); end
    CS = 1'b1;
    watch_pulses();
    n_checks++; if (done_n + err_n !== 0) begin n_fail++; $display("FAIL rstmid_release_pulses: got %0d expected 0", done_n + err_n); end
    n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL rstmid_release_led: got %b expected 00", led); end
    repeat (10) @(negedge clk);
    clear_bufs(); tx_buf[0] = 8'h82;
    xfer(40);
    n_checks++; if (rx_buf[0] !== 8'hFF) begin n_fail++; $display("FAIL rstmid_next_byte0: got %h expected ff", rx_buf[0]); end
    n_checks++; if (rx_buf[4] !== 8'h05) begin n_fail++; $display("FAIL rstmid_next_byte4: got %h expected 05", rx_buf[4]); end
    n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL rstmid_next_done: got %0d expected 1", done_n); end
    n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL rstmid_next_led: got %b expected 10", led); end
  endtask

  initial begin
    clear_bufs();
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_invalid_cmd();
    test_short_frame();
    test_long_frame();
    test_reset_midframe();
    chk("final_led", 32'(led), 32'h2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_jstk_responder.md
# pmod_jstk_responder

SPI mode-0 responder that emulates the PmodJSTK joystick module, the device end of the joystick SPI link. Samples MOSI, SCLK and CS from an external SPI initiator into the system clock domain. Returns a 5-byte joystick frame built from position and button inputs, and decodes the initiator's command byte into LED outputs. Used as a board-level joystick stand-in and as the bench counterpart for the joystick initiator.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SCLK/CS/MOSI synchronizers (min 2)
- NBYTES, 5, bytes per frame

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous, active-high reset
- SCLK  input  1  SPI clock from initiator, asynchronous to clk
- CS  input  1  active-low chip select from initiator, asynchronous
- MOSI  input  1  initiator data, asynchronous
- x_pos  input  10  joystick X value to report
- y_pos  input  10  joystick Y value to report
- buttons  input  3  bit0 stick press, bit1 BTN1, bit2 BTN2
- MISO  output  1  responder data to initiator
- led  output  2  LED state from the last valid command
- frame_done  output  1  one-clk pulse on a clean frame end
- frame_error  output  1  one-clk pulse on an aborted or over-length frame

## Operation
- SCLK, CS and MOSI each pass through SYNC_STAGES flops, then one edge-detect register. This gives rise/fall strobes for SCLK and CS.
- States:
  - IDLE: wait for the CS fall strobe, then go to ACTIVE.
  - ACTIVE: shift bits; on the CS rise strobe, go to IDLE.
  - WAIT_RELEASE: entered from reset; go to IDLE once synchronized CS is high.
- On CS fall, snapshot x_pos, y_pos and buttons, then load TX byte 0. The snapshot holds for the whole frame.
- TX bytes, MSB first:
  - byte 0: x_pos[7:0]
  - byte 1: {6'b0, x_pos[9:8]}
  - byte 2: y_pos[7:0]
  - byte 3: {6'b0, y_pos[9:8]}
  - byte 4: {5'b0, buttons}
  - bytes beyond NBYTES: 8'h00
- SCLK rise strobe: shift the synchronized MOSI into the RX register and increment the 3-bit bit counter.
- SCLK fall strobe: shift the TX register and present the next bit on MISO. When the bit counter wraps to 0, load the next TX byte and increment the byte counter. The byte counter saturates at NBYTES.
- When RX byte 0 completes, latch it as cmd.
- cmd is valid when cmd[7:2] == 6'b100000.
- CS rise with bit counter 0 and exactly NBYTES bytes complete:
  - pulse frame_done;
  - if cmd is valid, led <= cmd[1:0]; otherwise led is unchanged.
- CS rise in any other case (mid-byte, short frame, long frame): pulse frame_error, led unchanged.
- MISO is 0 whenever the state is not ACTIVE. No tristate; the pad level handles tristating.
- Reset values:
  - MISO 0, led 2'b00, frame_done 0, frame_error 0;
  - counters 0; state WAIT_RELEASE.
- rst asserted mid-frame aborts the frame with no pulse. The responder then stays in WAIT_RELEASE until CS has been seen high, so a partial frame is never decoded.
- SCLK edges while CS is high are ignored.
- A CS rise and an SCLK strobe in the same clk: CS rise wins and the SCLK strobe is discarded.

## Timing
- Input-to-strobe latency: SYNC_STAGES+1 clk.
- MISO MSB of byte 0 is valid SYNC_STAGES+2 clk after the CS fall.
- Each following bit is valid SYNC_STAGES+2 clk after the SCLK fall.
- Required SCLK high and low times: at least 2*(SYNC_STAGES+2) clk each. At 100 MHz clk and a 66.67 kHz SCLK the margin is large.
- Required CS setup before the first SCLK rise: at least SYNC_STAGES+2 clk.
- frame_done, frame_error and the led update occur SYNC_STAGES+2 clk after the CS rise. Both pulses last exactly 1 clk.

## Structure
- Shared package pmod_jstk_pkg:
  - JSTK_NBYTES = 5
  - JSTK_CMD_PREFIX = 6'b100000
  - state enum {WAIT_RELEASE, IDLE, ACTIVE}
  - byte-index constants
- One sub-module, spi_mode0_slave_shifter. It contains the synchronizers, edge detect, the bit counter and the TX/RX shift registers. It outputs a byte-done strobe, the RX byte and a TX-load request.
- The top level holds the FSM, the snapshot, byte selection and command decode.

## Test plan
- x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101, command 8'h81, 5-byte frame:
  - MISO returns A5, 02, 3C, 01, 05;
  - one frame_done pulse; led=2'b01.
- Change x_pos to 10'h3FF mid-frame: the frame still returns A5 and 02. The next frame returns FF and 03.
- Command 8'h43 (invalid prefix) in a complete frame: frame_done pulses, led keeps its prior value.
- Raise CS after 12 bits: frame_error pulses, led unchanged. The next full frame with command 8'h82 gives led=2'b10.
- 6-byte frame: byte 5 on MISO is 00, frame_error pulses, no led update.
- rst for 1 clk mid-frame with CS low:
  - outputs return to reset values;
  - SCLK edges are ignored until CS goes high;
  - the following full frame is decoded normally.
